// File: rtl/iob_soc_sut_boot_seq.sv
// Power-up/recovery sequencer: PLL lock -> DDR calibration -> PHY reset pulse -> system release.
// Loss of lock or calibration re-runs the sequence; a calibration timeout parks in FAULT until retry.
module iob_soc_sut_boot_seq #(
  parameter int USE_EXTMEM    = 1,
  parameter int PHY_RST_CYC   = 1000,
  parameter int PHY_WAIT_CYC  = 5000,
  parameter int CALIB_TIMEOUT = 2**22,
  parameter int CNT_W         = 23
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  input  logic       calib_done_i,
  input  logic       retry_i,
  output logic       sys_rst_o,
  output logic       phy_resetn_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [2:0] state_o,
  output logic [3:0] restarts_o
);

  // state      | meaning
  // WAIT_LOCK  | everything held in reset until the PLL reports lock
  // WAIT_CALIB | waiting for DDR calibration, bounded by CALIB_TIMEOUT
  // PHY_RST    | Ethernet PHY reset asserted for PHY_RST_CYC cycles
  // PHY_WAIT   | PHY released, settle for PHY_WAIT_CYC cycles
  // RUN        | system core out of reset
  // FAULT      | calibration timed out, held until retry_i
  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    WAIT_CALIB = 3'd1,
    PHY_RST    = 3'd2,
    PHY_WAIT   = 3'd3,
    RUN        = 3'd4,
    FAULT      = 3'd5
  } state_t;

  localparam bit               EXT        = (USE_EXTMEM != 0);
  localparam logic [CNT_W-1:0] LD_CALIB   = CNT_W'(CALIB_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LD_PHY_RST = CNT_W'(PHY_RST_CYC - 1);
  localparam logic [CNT_W-1:0] LD_PHY_WT  = CNT_W'(PHY_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lock_m, lock_s, calib_m, calib_s;
  logic             restart;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    restart   = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          if (EXT) begin
            state_nxt = WAIT_CALIB;
            cnt_nxt   = LD_CALIB;
          end else begin
            state_nxt = PHY_RST;
            cnt_nxt   = LD_PHY_RST;
          end
        end
      end
      // lock loss outranks calibration, which outranks the timeout
      WAIT_CALIB: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (calib_s) begin
          state_nxt = PHY_RST;
          cnt_nxt   = LD_PHY_RST;
        end else if (cnt == '0) begin
          state_nxt = FAULT;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      PHY_RST: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == '0) begin
          state_nxt = PHY_WAIT;
          cnt_nxt   = LD_PHY_WT;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      PHY_WAIT: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == '0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      RUN: begin
        if (!lock_s || (EXT && !calib_s)) begin
          state_nxt = WAIT_LOCK;
          restart   = 1'b1;
        end
      end
      FAULT: begin
        if (retry_i) state_nxt = WAIT_LOCK;
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // outputs decode the next state so they move on the same edge as state_o
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_m       <= 1'b0;
      lock_s       <= 1'b0;
      calib_m      <= 1'b0;
      calib_s      <= 1'b0;
      state        <= WAIT_LOCK;
      cnt          <= '0;
      restarts_o   <= 4'd0;
      sys_rst_o    <= 1'b1;
      phy_resetn_o <= 1'b0;
      ready_o      <= 1'b0;
      fault_o      <= 1'b0;
    end else begin
      lock_m       <= pll_locked_i;
      lock_s       <= lock_m;
      calib_m      <= calib_done_i;
      calib_s      <= calib_m;
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      if (restart && (restarts_o != 4'hF)) restarts_o <= restarts_o + 4'd1;
      sys_rst_o    <= (state_nxt != RUN);
      phy_resetn_o <= (state_nxt == PHY_WAIT) || (state_nxt == RUN);
      ready_o      <= (state_nxt == RUN);
      fault_o      <= (state_nxt == FAULT);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_iob_soc_sut_boot_seq.sv
// Bench for iob_soc_sut_boot_seq: two instances (with and without external memory) checked
// every cycle against an elapsed-time reference model, plus directed scenario checks.
module tb_iob_soc_sut_boot_seq;

  localparam int PR = 4;
  localparam int PW = 3;
  localparam int TO = 16;
  localparam logic [10:0] RST_VEC = 11'h080;

  logic clk = 1'b0;
  logic rst = 1'b1, lock = 1'b0, calib = 1'b0, retry = 1'b0;
  logic sys_rst_a, phy_a, ready_a, fault_a, sys_rst_b, phy_b, ready_b, fault_b;
  logic [2:0] st_a, st_b;
  logic [3:0] rs_a, rs_b;
  logic [10:0] obs_a, obs_b;

  int checks = 0;
  int failures = 0;

  int m_state[2];
  int m_el[2];
  int m_rs[2];
  bit ld1, ld2, cd1, cd2;

  always #5 clk = ~clk;

  iob_soc_sut_boot_seq #(.USE_EXTMEM(1), .PHY_RST_CYC(PR), .PHY_WAIT_CYC(PW),
                         .CALIB_TIMEOUT(TO), .CNT_W(5)) dut_a (
    .clk_i(clk), .rst_i(rst), .pll_locked_i(lock), .calib_done_i(calib), .retry_i(retry),
    .sys_rst_o(sys_rst_a), .phy_resetn_o(phy_a), .ready_o(ready_a), .fault_o(fault_a),
    .state_o(st_a), .restarts_o(rs_a));

  iob_soc_sut_boot_seq #(.USE_EXTMEM(0), .PHY_RST_CYC(PR), .PHY_WAIT_CYC(PW),
                         .CALIB_TIMEOUT(TO), .CNT_W(5)) dut_b (
    .clk_i(clk), .rst_i(rst), .pll_locked_i(lock), .calib_done_i(calib), .retry_i(retry),
    .sys_rst_o(sys_rst_b), .phy_resetn_o(phy_b), .ready_o(ready_b), .fault_o(fault_b),
    .state_o(st_b), .restarts_o(rs_b));

  assign obs_a = {st_a, sys_rst_a, phy_a, ready_a, fault_a, rs_a};
  assign obs_b = {st_b, sys_rst_b, phy_b, ready_b, fault_b, rs_b};

  // Reference: each phase lasts a fixed number of cycles measured by an elapsed count.
  task automatic model_step(input int k, input bit ext, input bit ls, input bit cs);
    int ns;
    if (rst) begin
      m_state[k] = 0; m_el[k] = 0; m_rs[k] = 0;
      return;
    end
    ns = m_state[k];
    case (m_state[k])
      0: if (ls) ns = ext ? 1 : 2;
      1: if (!ls) ns = 0; else if (cs) ns = 2; else if (m_el[k] + 1 >= TO) ns = 5;
      2: if (!ls) ns = 0; else if (m_el[k] + 1 >= PR) ns = 3;
      3: if (!ls) ns = 0; else if (m_el[k] + 1 >= PW) ns = 4;
      4: if (!ls || (ext && !cs)) begin
           ns = 0;
           if (m_rs[k] < 15) m_rs[k] = m_rs[k] + 1;
         end
      5: if (retry) ns = 0;
      default: ns = 0;
    endcase
    m_el[k] = (ns == m_state[k]) ? m_el[k] + 1 : 0;
    m_state[k] = ns;
  endtask

  always @(posedge clk) begin : model
    bit ls, cs;
    ls = ld2; cs = cd2;
    model_step(0, 1'b1, ls, cs);
    model_step(1, 1'b0, ls, cs);
    if (rst) begin
      ld1 = 1'b0; ld2 = 1'b0; cd1 = 1'b0; cd2 = 1'b0;
    end else begin
      ld2 = ld1; ld1 = lock; cd2 = cd1; cd1 = calib;
    end
  end

  function automatic logic [10:0] exp_vec(input int k);
    logic [2:0] sc;
    logic [3:0] rc;
    sc = 3'(m_state[k]);
    rc = 4'(m_rs[k]);
    return {sc, m_state[k] != 4, (m_state[k] == 3) || (m_state[k] == 4),
            m_state[k] == 4, m_state[k] == 5, rc};
  endfunction

  task automatic test_reset();
    rst = 1'b1; lock = 1'b1; calib = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== RST_VEC || obs_b !== RST_VEC) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got a=%h b=%h required=%h", i, obs_a, obs_b, RST_VEC);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    int t2, trun, n2, n3;
    t2 = -1; trun = -1; n2 = 0; n3 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)}) begin
        failures++;
        $display("FAIL nominal_model cyc=%0d got a=%h b=%h required a=%h b=%h",
                 i, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
      if (st_a == 3'd2 && t2 < 0) t2 = i;
      if (sys_rst_a === 1'b0 && trun < 0) trun = i;
      if (st_a == 3'd2) n2++;
      if (st_a == 3'd3) n3++;
    end
    checks++;
    if (t2 < 0 || trun < 0 || trun - t2 != PR + PW) begin
      failures++;
      $display("FAIL nominal_release_delay got %0d (state2 at %0d) required %0d", trun - t2, t2, PR + PW);
    end
    checks++;
    if (n2 != PR || n3 != PW) begin
      failures++;
      $display("FAIL nominal_phy_pulse got low=%0d wait=%0d required low=%0d wait=%0d", n2, n3, PR, PW);
    end
    checks++;
    if (ready_a !== 1'b1 || sys_rst_a !== 1'b0 || ready_b !== 1'b1) begin
      failures++;
      $display("FAIL nominal_run got ready_a=%b sys_rst_a=%b ready_b=%b required 1 0 1",
               ready_a, sys_rst_a, ready_b);
    end
  endtask

  task automatic test_timeout();
    int n1;
    n1 = 0;
    rst = 1'b1; lock = 1'b1; calib = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)}) begin
        failures++;
        $display("FAIL timeout_model cyc=%0d got a=%h b=%h required a=%h b=%h",
                 i, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
      if (st_a == 3'd1) n1++;
    end
    checks++;
    if (n1 != TO) begin
      failures++;
      $display("FAIL timeout_length got %0d required %0d", n1, TO);
    end
    checks++;
    if (st_a !== 3'd5 || fault_a !== 1'b1 || sys_rst_a !== 1'b1 || phy_a !== 1'b0) begin
      failures++;
      $display("FAIL timeout_fault got st=%0d fault=%b sys_rst=%b phy=%b required 5 1 1 0",
               st_a, fault_a, sys_rst_a, phy_a);
    end
    calib = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (st_a !== 3'd5 || fault_a !== 1'b1) begin
      failures++;
      $display("FAIL fault_sticky got st=%0d fault=%b required 5 1", st_a, fault_a);
    end
    retry = 1'b1;
    @(negedge clk);
    retry = 1'b0;
    checks++;
    if (st_a !== 3'd0 || fault_a !== 1'b0) begin
      failures++;
      $display("FAIL retry_exit got st=%0d fault=%b required 0 0", st_a, fault_a);
    end
  endtask

  task automatic test_lock_loss_run();
    bit seen_run;
    seen_run = 1'b0;
    for (int i = 0; i < 40 && !seen_run; i++) begin
      @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)}) begin
        failures++;
        $display("FAIL runloss_model cyc=%0d got a=%h b=%h required a=%h b=%h",
                 i, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
      if (st_a == 3'd4) seen_run = 1'b1;
    end
    checks++;
    if (!seen_run) begin
      failures++;
      $display("FAIL reach_run got st=%0d required 4 within 40 cycles", st_a);
    end
    lock = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      checks++;
      if (sys_rst_a !== (e == 3)) begin
        failures++;
        $display("FAIL runloss_edge edge=%0d got sys_rst=%b required %b", e, sys_rst_a, e == 3);
      end
      if (e == 1) lock = 1'b1;
    end
    checks++;
    if (rs_a !== 4'd1) begin
      failures++;
      $display("FAIL runloss_restarts got %0d required 1", rs_a);
    end
    seen_run = 1'b0;
    for (int i = 0; i < 40 && !seen_run; i++) begin
      @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)}) begin
        failures++;
        $display("FAIL rerun_model cyc=%0d got a=%h b=%h required a=%h b=%h",
                 i, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
      if (st_a == 3'd4) seen_run = 1'b1;
    end
    checks++;
    if (!seen_run) begin
      failures++;
      $display("FAIL rerun_reach_run got st=%0d required 4", st_a);
    end
  endtask

  task automatic test_lock_loss_phy_rst();
    bit seen1;
    int n2;
    seen1 = 1'b0; n2 = 0;
    rst = 1'b1; lock = 1'b1; calib = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20 && !seen1; i++) begin
      @(negedge clk);
      if (st_a == 3'd1) seen1 = 1'b1;
    end
    lock = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      checks++;
      if (phy_a !== 1'b0 || {obs_a, obs_b} !== {exp_vec(0), exp_vec(1)}) begin
        failures++;
        $display("FAIL phyloss_edge edge=%0d got phy=%b a=%h required phy=0 a=%h", e, phy_a, obs_a, exp_vec(0));
      end
    end
    checks++;
    if (st_a !== 3'd0) begin
      failures++;
      $display("FAIL phyloss_state got %0d required 0", st_a);
    end
    lock = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)}) begin
        failures++;
        $display("FAIL phyloss_model cyc=%0d got a=%h b=%h required a=%h b=%h",
                 i, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
      if (st_a == 3'd2) n2++;
    end
    checks++;
    if (n2 != PR || st_a !== 3'd4) begin
      failures++;
      $display("FAIL phyloss_reload got low=%0d st=%0d required low=%0d st=4", n2, st_a, PR);
    end
  endtask

  task automatic test_saturation();
    bit seen3;
    seen3 = 1'b0;
    for (int ev = 0; ev < 17; ev++) begin
      lock = 1'b0;
      @(negedge clk);
      lock = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        checks++;
        if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)}) begin
          failures++;
          $display("FAIL sat_model ev=%0d cyc=%0d got a=%h b=%h required a=%h b=%h",
                   ev, i, obs_a, obs_b, exp_vec(0), exp_vec(1));
        end
      end
    end
    checks++;
    if (rs_a !== 4'd15 || st_a !== 3'd4) begin
      failures++;
      $display("FAIL sat_restarts got rs=%0d st=%0d required rs=15 st=4", rs_a, st_a);
    end
    lock = 1'b0;
    @(negedge clk);
    lock = 1'b1;
    for (int i = 0; i < 30 && !seen3; i++) begin
      @(negedge clk);
      if (st_a == 3'd3) seen3 = 1'b1;
    end
    checks++;
    if (!seen3) begin
      failures++;
      $display("FAIL sat_reach_phy_wait got st=%0d required 3", st_a);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (obs_a !== RST_VEC || obs_b !== RST_VEC) begin
      failures++;
      $display("FAIL reset_priority got a=%h b=%h required %h", obs_a, obs_b, RST_VEC);
    end
  endtask

  task automatic test_extmem0();
    int seq[$];
    bit seen5;
    seen5 = 1'b0;
    rst = 1'b1; lock = 1'b1; calib = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)}) begin
        failures++;
        $display("FAIL noext_model cyc=%0d got a=%h b=%h required a=%h b=%h",
                 i, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
      if (seq.size() == 0 || seq[$] != int'(st_b)) seq.push_back(int'(st_b));
      if (st_b == 3'd5) seen5 = 1'b1;
    end
    checks++;
    if (seq.size() != 4 || seq[0] != 0 || seq[1] != 2 || seq[2] != 3 || seq[3] != 4 || seen5) begin
      failures++;
      $display("FAIL noext_sequence got %0d states (last %0d, fault=%b) required 0,2,3,4",
               seq.size(), seq[$], seen5);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)}) begin
        failures++;
        $display("FAIL random_model cyc=%0d got a=%h b=%h required a=%h b=%h",
                 i, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 29) == 0) lock = ~lock;
      if ($urandom_range(0, 39) == 0) calib = ~calib;
      retry = ($urandom_range(0, 9) == 0);
    end
    rst = 1'b0; retry = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_lock_loss_run();
    test_lock_loss_phy_rst();
    test_saturation();
    test_extmem0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
